stack_unit: RTL and testbench

- Stack engine for the CPU's parameter and return stacks. Executes one push or pop per request.
- Reads the current stack pointer from the register-file outputs (PSP = register 1, RSP = register 2).
- Performs the data-memory access through a req/ack handshake, then drives the register-file write port (write address, write data, write strobe) to commit the updated pointer.
- Sits between the control unit, the register file write port and the data-memory arbiter.

---
 rtl/stack_unit_pkg.sv | 42 ++++
 rtl/stack_unit.sv | 159 +++++++++++++++
 tb/tb_stack_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_unit_pkg.sv
// -----------------------------------------------------------------------------
// stack_unit_pkg
// Shared definitions for the parameter/return stack engine:
//   - FSM state encoding
//   - register-file indices of the pointer registers
//   - default stack bases and depth
//   - the latched-operation record carried from IDLE through WB
// -----------------------------------------------------------------------------
package stack_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    REG_PC  = 4'd0,
    REG_PSP = 4'd1,
    REG_RSP = 4'd2,
    REG_IOR = 4'd15
  } reg_idx_e;

  localparam logic [15:0] DEF_PSP_BASE = 16'd192;
  localparam logic [15:0] DEF_RSP_BASE = 16'd224;
  localparam logic [15:0] DEF_DEPTH    = 16'd32;

  // Everything about one push/pop that must survive after the request cycle.
  typedef struct packed {
    logic        stack;   // 0 = parameter stack, 1 = return stack
    logic        push;    // 1 = push, 0 = pop
    logic [15:0] addr;    // memory address of the access
    logic [15:0] new_sp;  // pointer value committed in WB
    logic [15:0] data;    // push value
  } op_t;

  // Register-file slot holding the pointer of the selected stack.
  function automatic reg_idx_e sp_reg(input logic stack);
    return stack ? REG_RSP : REG_PSP;
  endfunction

endpackage

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// Push/pop engine for the CPU parameter and return stacks. One operation per
// request: latch the request, perform one data-memory access over a req/ack
// handshake, then write the updated stack pointer back to the register file.
// Stacks grow upward; all pointer arithmetic is 16-bit modulo.
//
// Configuration macro: STACK_CHECK_EN
//   defined   - overflow/underflow requests are rejected in IDLE and reported
//               with a one-cycle o_DONE + o_ERR pulse (no memory access, no
//               pointer write)
//   undefined - no bounds checks, o_ERR stays 0, pointers wrap
//
// Ports:
//   c_CLOCK / c_RESET         clock, asynchronous active-high reset
//   i_REQ, i_STACK, i_PUSH    operation request (sampled in IDLE only)
//   i_DATA                    push value
//   i_PSP, i_RSP              current pointers from the register file
//   o_BUSY, o_DONE, o_ERR     status; o_DONE/o_ERR are one-cycle pulses
//   o_Q                       last popped value
//   o_MREQ, o_MWE, o_MADDR,
//   o_MDATA, i_MACK, i_MDATA  data-memory handshake
//   o_WADDR, o_WDATA, o_WRITE register-file write port for the new pointer
// -----------------------------------------------------------------------------
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter logic [15:0] PSP_BASE = DEF_PSP_BASE,
  parameter logic [15:0] RSP_BASE = DEF_RSP_BASE,
  parameter logic [15:0] DEPTH    = DEF_DEPTH
) (
  input  logic        c_CLOCK,
  input  logic        c_RESET,
  input  logic        i_REQ,
  input  logic        i_STACK,
  input  logic        i_PUSH,
  input  logic [15:0] i_DATA,
  input  logic [15:0] i_PSP,
  input  logic [15:0] i_RSP,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERR,
  output logic [15:0] o_Q,
  output logic        o_MREQ,
  output logic        o_MWE,
  output logic [15:0] o_MADDR,
  output logic [15:0] o_MDATA,
  input  logic        i_MACK,
  input  logic [15:0] i_MDATA,
  output logic [3:0]  o_WADDR,
  output logic [15:0] o_WDATA,
  output logic        o_WRITE
);

  state_e      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] q_q, q_d;
  logic        err_q, err_d;   // high for the single cycle after a rejection

  logic [15:0] sp_sel;
  op_t         req_op;
  logic        reject;

  // Operation decoded from the request inputs; only captured in IDLE.
  always_comb begin
    sp_sel        = i_STACK ? i_RSP : i_PSP;
    req_op.stack  = i_STACK;
    req_op.push   = i_PUSH;
    req_op.data   = i_DATA;
    req_op.addr   = i_PUSH ? sp_sel : sp_sel - 16'd1;
    req_op.new_sp = i_PUSH ? sp_sel + 16'd1 : sp_sel - 16'd1;
  end

`ifdef STACK_CHECK_EN
  logic [15:0] base_sel;
  logic [15:0] limit_sel;

  assign base_sel  = i_STACK ? RSP_BASE : PSP_BASE;
  assign limit_sel = base_sel + DEPTH;
  // Push into a full stack or pop from an empty one.
  assign reject    = i_PUSH ? (sp_sel >= limit_sel) : (sp_sel <= base_sel);
`else
  logic unused_cfg;

  assign reject     = 1'b0;
  assign unused_cfg = ^{PSP_BASE, RSP_BASE, DEPTH};
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch to hold it.
    state_d = state_q;
    op_d    = op_q;
    q_d     = q_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // err_q marks the busy cycle after a rejection: requests are ignored.
        if (i_REQ && !err_q) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            op_d    = req_op;
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (i_MACK) begin
          if (!op_q.push) begin
            q_d = i_MDATA;
          end
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      q_q     <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register updates from
      // pre-edge values, regardless of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from registers only, so reset clears them at once.
  assign o_BUSY  = (state_q != ST_IDLE) || err_q;
  assign o_DONE  = (state_q == ST_WB) || err_q;
  assign o_ERR   = err_q;
  assign o_Q     = q_q;

  assign o_MREQ  = (state_q == ST_MEM);
  assign o_MWE   = o_MREQ && op_q.push;
  assign o_MADDR = op_q.addr;
  assign o_MDATA = op_q.data;

  assign o_WRITE = (state_q == ST_WB);
  assign o_WADDR = o_WRITE ? sp_reg(op_q.stack) : 4'd0;
  assign o_WDATA = o_WRITE ? op_q.new_sp : 16'd0;

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit. The bench plays register file and data
// memory; expected addresses, pointers and popped values come from a
// behavioural model (pointer array + sparse memory) kept here.
// Honours STACK_CHECK_EN to predict rejections.
// -----------------------------------------------------------------------------
module tb_stack_unit;

  logic        c_CLOCK = 1'b0;
  logic        c_RESET = 1'b1;
  logic        i_REQ   = 1'b0;
  logic        i_STACK = 1'b0;
  logic        i_PUSH  = 1'b0;
  logic [15:0] i_DATA  = 16'd0;
  logic [15:0] i_PSP   = 16'd0;
  logic [15:0] i_RSP   = 16'd0;
  logic        i_MACK  = 1'b0;
  logic [15:0] i_MDATA = 16'd0;
  logic        o_BUSY, o_DONE, o_ERR, o_MREQ, o_MWE, o_WRITE;
  logic [15:0] o_Q, o_MADDR, o_MDATA, o_WDATA;
  logic [3:0]  o_WADDR;

  int errors = 0;
  int checks = 0;

  // Reference state: register file, reference memory, last popped value.
  logic [15:0] rf [0:15];
  logic [15:0] ref_mem [int];
  logic [15:0] env_mem [int];
  logic [15:0] exp_q;

  stack_unit dut (
    .c_CLOCK (c_CLOCK),
    .c_RESET (c_RESET),
    .i_REQ   (i_REQ),
    .i_STACK (i_STACK),
    .i_PUSH  (i_PUSH),
    .i_DATA  (i_DATA),
    .i_PSP   (i_PSP),
    .i_RSP   (i_RSP),
    .o_BUSY  (o_BUSY),
    .o_DONE  (o_DONE),
    .o_ERR   (o_ERR),
    .o_Q     (o_Q),
    .o_MREQ  (o_MREQ),
    .o_MWE   (o_MWE),
    .o_MADDR (o_MADDR),
    .o_MDATA (o_MDATA),
    .i_MACK  (i_MACK),
    .i_MDATA (i_MDATA),
    .o_WADDR (o_WADDR),
    .o_WDATA (o_WDATA),
    .o_WRITE (o_WRITE)
  );

  always #5 c_CLOCK = ~c_CLOCK;

  // Unwritten memory words read back as a recognisable address pattern.
  function automatic logic [15:0] mem_init(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] env_read(input int a);
    return env_mem.exists(a) ? env_mem[a] : mem_init(a);
  endfunction

  function automatic logic [15:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic tick();
    @(posedge c_CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete push/pop with the bench acting as memory and register file.
  task automatic do_op(input logic stack, input logic push, input logic [15:0] data,
                       input int waits, input bit glitch);
    logic [15:0] sp, base, addr, new_sp;
    bit          rejected;
    int          ri;
    ri       = stack ? 2 : 1;
    sp       = rf[ri];
    base     = stack ? 16'd224 : 16'd192;
    addr     = push ? sp : sp - 16'd1;
    new_sp   = push ? sp + 16'd1 : sp - 16'd1;
    rejected = 1'b0;
`ifdef STACK_CHECK_EN
    rejected = push ? (sp >= base + 16'd32) : (sp <= base);
`endif
    i_PSP   = rf[1];
    i_RSP   = rf[2];
    i_REQ   = 1'b1;
    i_STACK = stack;
    i_PUSH  = push;
    i_DATA  = data;
    i_MACK  = 1'($urandom_range(0, 1));  // ack in IDLE must be ignored
    tick();
    // Disturb every request input; the operation in flight must not notice.
    i_REQ   = 1'b0;
    i_MACK  = 1'b0;
    i_STACK = ~stack;
    i_PUSH  = ~push;
    i_DATA  = 16'($urandom);
    i_PSP   = 16'($urandom);
    i_RSP   = 16'($urandom);
    if (rejected) begin
      check("rej_done", o_DONE, 16'd1);
      check("rej_err", o_ERR, 16'd1);
      check("rej_busy", o_BUSY, 16'd1);
      check("rej_mreq", o_MREQ, 16'd0);
      check("rej_write", o_WRITE, 16'd0);
      tick();
      check("rej_after_busy", o_BUSY, 16'd0);
      check("rej_after_done", o_DONE, 16'd0);
      check("rej_after_mreq", o_MREQ, 16'd0);
      return;
    end
    for (int i = 0; i < waits; i++) begin
      check("wait_mreq", o_MREQ, 16'd1);
      check("wait_maddr", o_MADDR, addr);
      check("wait_mwe", o_MWE, 16'(push));
      if (push) check("wait_mdata", o_MDATA, data);
      check("wait_done", o_DONE, 16'd0);
      i_REQ = glitch && (i == 0);
      tick();
    end
    i_REQ = 1'b0;
    check("mreq", o_MREQ, 16'd1);
    check("maddr", o_MADDR, addr);
    check("mwe", o_MWE, 16'(push));
    check("busy", o_BUSY, 16'd1);
    if (push) check("mdata", o_MDATA, data);
    i_MACK  = 1'b1;
    i_MDATA = env_read(int'(o_MADDR));
    if (o_MREQ && o_MWE) env_mem[int'(o_MADDR)] = o_MDATA;
    tick();
    i_MACK  = 1'b0;
    i_MDATA = 16'($urandom);
    if (push) ref_mem[int'(addr)] = data;
    else      exp_q = ref_read(int'(addr));
    rf[ri] = new_sp;
    check("wb_write", o_WRITE, 16'd1);
    check("wb_done", o_DONE, 16'd1);
    check("wb_err", o_ERR, 16'd0);
    check("wb_mreq", o_MREQ, 16'd0);
    check("wb_waddr", 16'(o_WADDR), 16'(ri));
    check("wb_wdata", o_WDATA, new_sp);
    check("wb_q", o_Q, exp_q);
    tick();
    check("idle_write", o_WRITE, 16'd0);
    check("idle_done", o_DONE, 16'd0);
    check("idle_busy", o_BUSY, 16'd0);
    check("idle_mreq", o_MREQ, 16'd0);
    check("idle_q", o_Q, exp_q);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'd0;
    exp_q = 16'd0;

    // Reset state.
    #1;
    check("rst_busy", o_BUSY, 16'd0);
    check("rst_done", o_DONE, 16'd0);
    check("rst_err", o_ERR, 16'd0);
    check("rst_mreq", o_MREQ, 16'd0);
    check("rst_write", o_WRITE, 16'd0);
    check("rst_waddr", 16'(o_WADDR), 16'd0);
    check("rst_q", o_Q, 16'd0);
    tick();
    tick();
    c_RESET = 1'b0;
    tick();

    // Push P at the base, zero-wait ack.
    rf[1] = 16'd192;
    do_op(1'b0, 1'b1, 16'hBEEF, 0, 1'b0);
    check("push_p_sp", rf[1], 16'd193);

    // Pop R from 230 with three wait states.
    rf[2]          = 16'd230;
    env_mem[229]   = 16'h1234;
    ref_mem[229]   = 16'h1234;
    do_op(1'b1, 1'b0, 16'h0000, 3, 1'b0);
    check("pop_r_q", o_Q, 16'h1234);

    // Push keeps o_Q; request pulsed during MEM is ignored.
    do_op(1'b0, 1'b1, 16'($urandom), 2, 1'b1);

    // Reset while a push waits for its ack.
    i_PSP   = rf[1];
    i_RSP   = rf[2];
    i_REQ   = 1'b1;
    i_STACK = 1'b0;
    i_PUSH  = 1'b1;
    i_DATA  = 16'hCAFE;
    tick();
    i_REQ = 1'b0;
    check("pre_rst_mreq", o_MREQ, 16'd1);
    tick();
    #2;
    c_RESET = 1'b1;
    #1;
    check("mid_rst_mreq", o_MREQ, 16'd0);
    check("mid_rst_busy", o_BUSY, 16'd0);
    check("mid_rst_write", o_WRITE, 16'd0);
    exp_q = 16'd0;
    tick();
    c_RESET = 1'b0;
    tick();
    check("post_rst_write", o_WRITE, 16'd0);
    check("post_rst_q", o_Q, 16'd0);
    do_op(1'b0, 1'b1, 16'h5A5A, 1, 1'b0);

    // Boundary cases: rejected with STACK_CHECK_EN, wrap/normal otherwise.
    rf[1] = 16'd192;
    do_op(1'b0, 1'b0, 16'd0, 0, 1'b0);
    rf[2] = 16'd256;
    do_op(1'b1, 1'b1, 16'h7777, 1, 1'b0);
    rf[1] = 16'd0;
    do_op(1'b0, 1'b0, 16'd0, 0, 1'b0);
    rf[2] = 16'd255;
    do_op(1'b1, 1'b1, 16'h4242, 0, 1'b0);
    rf[1] = 16'd193;
    do_op(1'b0, 1'b0, 16'd0, 2, 1'b0);

    // Random walk over both stacks from their bases.
    rf[1] = 16'd192;
    rf[2] = 16'd224;
    for (int n = 0; n < 60; n++) begin
      int  w;
      w = int'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), 16'($urandom),
            w, (w > 0) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
